dog_anim_ctl: RTL and testbench



---
 rtl/dog_anim_ctl.sv | 269 ++++++++++++++++++++++++++
 tb/tb_dog_anim_ctl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dog_anim_ctl.sv
`default_nettype none
// ============================================================================
// Module      : dog_anim_ctl
// Description : Frame-paced sequencer for the dog cut-scenes (intro walk /
//               sniff / jump, catch pop-up, laugh pop-up). Drives dog ROM
//               image select, sprite position and visibility each frame.
// Revision    : 1.0 - initial release
// ============================================================================
module dog_anim_ctl #(
  parameter int WALK_START_X = 100,
  parameter int WALK_END_X   = 400,
  parameter int GROUND_Y     = 500,
  parameter int JUMP_PEAK_Y  = 380,
  parameter int HIDE_Y       = 560,
  parameter int POP_Y        = 460,
  parameter int LAUGH_X      = 480,
  parameter int WALK_STEP    = 2,
  parameter int JUMP_STEP    = 4,
  parameter int RISE_STEP    = 2,
  parameter int ANIM_DIV     = 6,
  parameter int SNIFF_TICKS  = 60,
  parameter int HOLD_TICKS   = 90
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        start_intro,
  input  logic        start_catch,
  input  logic        start_laugh,
  input  logic [10:0] catch_x,
  output logic [3:0]  dog_select,
  output logic [10:0] dog_xpos,
  output logic [10:0] dog_ypos,
  output logic        dog_visible,
  output logic        dog_bird_visible,
  output logic        busy,
  output logic        done
);

  // Tick counter covers the longer of the two timed states.
  localparam int C_CNT_MAX = (SNIFF_TICKS > HOLD_TICKS) ? SNIFF_TICKS : HOLD_TICKS;
  localparam int C_CNT_W   = ($clog2(C_CNT_MAX) > 0) ? $clog2(C_CNT_MAX) : 1;
  localparam int C_ANIM_W  = ($clog2(ANIM_DIV) > 0) ? $clog2(ANIM_DIV) : 1;

  localparam logic [2:0] c_idle      = 3'd0;
  localparam logic [2:0] c_walk      = 3'd1;
  localparam logic [2:0] c_sniff     = 3'd2;
  localparam logic [2:0] c_jump_up   = 3'd3;
  localparam logic [2:0] c_jump_down = 3'd4;
  localparam logic [2:0] c_rise      = 3'd5;
  localparam logic [2:0] c_hold      = 3'd6;
  localparam logic [2:0] c_sink      = 3'd7;

  localparam logic c_scene_catch = 1'b0;
  localparam logic c_scene_laugh = 1'b1;

  // 12-bit forms so step arithmetic can be compared without wrap.
  localparam logic [11:0] c_walk_end  = 12'(WALK_END_X);
  localparam logic [11:0] c_hide_y    = 12'(HIDE_Y);
  localparam logic [11:0] c_peak_lim  = 12'(JUMP_PEAK_Y + JUMP_STEP);
  localparam logic [11:0] c_pop_lim   = 12'(POP_Y + RISE_STEP);
  localparam logic [11:0] c_walk_step = 12'(WALK_STEP);
  localparam logic [11:0] c_jump_step = 12'(JUMP_STEP);
  localparam logic [11:0] c_rise_step = 12'(RISE_STEP);

  localparam logic [C_CNT_W-1:0]  c_sniff_last = C_CNT_W'(SNIFF_TICKS - 1);
  localparam logic [C_CNT_W-1:0]  c_hold_last  = C_CNT_W'(HOLD_TICKS - 1);
  localparam logic [C_ANIM_W-1:0] c_anim_last  = C_ANIM_W'(ANIM_DIV - 1);

  logic [2:0]          state_q, state_d;
  logic                scene_q, scene_d;
  logic [3:0]          sel_q, sel_d;
  logic [10:0]         x_q, x_d;
  logic [10:0]         y_q, y_d;
  logic                vis_q, vis_d;
  logic                bird_q, bird_d;
  logic                done_q, done_d;
  logic [C_CNT_W-1:0]  cnt_q, cnt_d;
  logic [C_ANIM_W-1:0] anim_q, anim_d;

  logic [11:0] w_x_inc;
  logic [11:0] w_y_jinc;
  logic [11:0] w_y_rinc;
  logic        w_anim_wrap;

  assign w_x_inc     = {1'b0, x_q} + c_walk_step;
  assign w_y_jinc    = {1'b0, y_q} + c_jump_step;
  assign w_y_rinc    = {1'b0, y_q} + c_rise_step;
  assign w_anim_wrap = (anim_q == c_anim_last);

  // Next-state, position and image computation; everything past IDLE moves only on frame_tick.
  always_comb begin
    state_d = state_q;
    scene_d = scene_q;
    sel_d   = sel_q;
    x_d     = x_q;
    y_d     = y_q;
    vis_d   = vis_q;
    bird_d  = bird_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    anim_d  = anim_q;

    // Laugh image flips 7<->8 on a cadence that runs across RISE/HOLD/SINK.
    if (frame_tick && scene_q == c_scene_laugh &&
        (state_q == c_rise || state_q == c_hold || state_q == c_sink)) begin
      if (w_anim_wrap) begin
        anim_d = '0;
        sel_d  = (sel_q == 4'd7) ? 4'd8 : 4'd7;
      end else begin
        anim_d = anim_q + 1'b1;
      end
    end

    case (state_q)
      c_idle: begin
        cnt_d  = '0;
        anim_d = '0;
        if (start_intro) begin
          state_d = c_walk;
          x_d     = 11'(WALK_START_X);
          y_d     = 11'(GROUND_Y);
          vis_d   = 1'b1;
          sel_d   = 4'd0;
        end else if (start_catch) begin
          state_d = c_rise;
          scene_d = c_scene_catch;
          x_d     = catch_x;
          y_d     = 11'(HIDE_Y);
          bird_d  = 1'b1;
          vis_d   = 1'b0;
          sel_d   = 4'd0;
        end else if (start_laugh) begin
          state_d = c_rise;
          scene_d = c_scene_laugh;
          x_d     = 11'(LAUGH_X);
          y_d     = 11'(HIDE_Y);
          vis_d   = 1'b1;
          sel_d   = 4'd7;
        end
      end

      c_walk: if (frame_tick) begin
        if (w_anim_wrap) begin
          anim_d = '0;
          sel_d  = (sel_q == 4'd3) ? 4'd0 : sel_q + 4'd1;
        end else begin
          anim_d = anim_q + 1'b1;
        end
        if (w_x_inc >= c_walk_end) begin
          x_d     = 11'(WALK_END_X);
          state_d = c_sniff;
          sel_d   = 4'd4;
          cnt_d   = '0;
          anim_d  = '0;
        end else begin
          x_d = w_x_inc[10:0];
        end
      end

      c_sniff: if (frame_tick) begin
        if (cnt_q == c_sniff_last) begin
          state_d = c_jump_up;
          sel_d   = 4'd5;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      c_jump_up: if (frame_tick) begin
        if ({1'b0, y_q} <= c_peak_lim) begin
          y_d     = 11'(JUMP_PEAK_Y);
          state_d = c_jump_down;
          sel_d   = 4'd6;
        end else begin
          y_d = y_q - c_jump_step[10:0];
        end
      end

      c_jump_down: if (frame_tick) begin
        if (w_y_jinc >= c_hide_y) begin
          state_d = c_idle;
          done_d  = 1'b1;
        end else begin
          y_d = w_y_jinc[10:0];
        end
      end

      c_rise: if (frame_tick) begin
        if ({1'b0, y_q} <= c_pop_lim) begin
          y_d     = 11'(POP_Y);
          state_d = c_hold;
          cnt_d   = '0;
        end else begin
          y_d = y_q - c_rise_step[10:0];
        end
      end

      c_hold: if (frame_tick) begin
        if (cnt_q == c_hold_last) begin
          state_d = c_sink;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      c_sink: if (frame_tick) begin
        if (w_y_rinc >= c_hide_y) begin
          state_d = c_idle;
          done_d  = 1'b1;
        end else begin
          y_d = w_y_rinc[10:0];
        end
      end

      default: state_d = c_idle;
    endcase

    // Scene completion lands on the IDLE resting values.
    if (done_d) begin
      sel_d  = 4'd0;
      x_d    = 11'(WALK_START_X);
      y_d    = 11'(HIDE_Y);
      vis_d  = 1'b0;
      bird_d = 1'b0;
      cnt_d  = '0;
      anim_d = '0;
    end
  end

  // State and output registers; reset aborts any scene without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= c_idle;
      scene_q <= c_scene_catch;
      sel_q   <= 4'd0;
      x_q     <= 11'(WALK_START_X);
      y_q     <= 11'(HIDE_Y);
      vis_q   <= 1'b0;
      bird_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      anim_q  <= '0;
    end else begin
      state_q <= state_d;
      scene_q <= scene_d;
      sel_q   <= sel_d;
      x_q     <= x_d;
      y_q     <= y_d;
      vis_q   <= vis_d;
      bird_q  <= bird_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      anim_q  <= anim_d;
    end
  end

  assign dog_select       = sel_q;
  assign dog_xpos         = x_q;
  assign dog_ypos         = y_q;
  assign dog_visible      = vis_q;
  assign dog_bird_visible = bird_q;
  assign busy             = (state_q != c_idle);
  assign done             = done_q;

endmodule
`default_nettype wire

// File: tb/tb_dog_anim_ctl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dog_anim_ctl
// Description : Scoreboard bench for dog_anim_ctl. Stimulus pushes expected
//               output vectors; a monitor pops and compares after each frame
//               tick or marked command/snapshot cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dog_anim_ctl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic        start_intro = 1'b0;
  logic        start_catch = 1'b0;
  logic        start_laugh = 1'b0;
  logic [10:0] catch_x = 11'd0;
  logic [3:0]  dog_select;
  logic [10:0] dog_xpos;
  logic [10:0] dog_ypos;
  logic        dog_visible;
  logic        dog_bird_visible;
  logic        busy;
  logic        done;

  logic        mon_strobe = 1'b0;

  typedef struct {
    string nm;
    int    sel;
    int    x;
    int    y;
    bit    vis;
    bit    bird;
    bit    bsy;
    bit    dn;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   done_total = 0;

  dog_anim_ctl dut (
    .clk              (clk),
    .rst              (rst),
    .frame_tick       (frame_tick),
    .start_intro      (start_intro),
    .start_catch      (start_catch),
    .start_laugh      (start_laugh),
    .catch_x          (catch_x),
    .dog_select       (dog_select),
    .dog_xpos         (dog_xpos),
    .dog_ypos         (dog_ypos),
    .dog_visible      (dog_visible),
    .dog_bird_visible (dog_bird_visible),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  // Count done pulses independently of the scoreboard.
  always @(negedge clk) if (done === 1'b1) done_total++;

  function automatic exp_t mk(string nm, int sel, int x, int y, bit vis, bit bird, bit bsy, bit dn);
    exp_t e;
    e.nm = nm; e.sel = sel; e.x = x; e.y = y;
    e.vis = vis; e.bird = bird; e.bsy = bsy; e.dn = dn;
    return e;
  endfunction

  function automatic exp_t idle_exp(string nm, bit dn);
    return mk(nm, 0, 100, 560, 0, 0, 0, dn);
  endfunction

  // Expected outputs after intro tick k (k=0 is the acceptance cycle).
  function automatic exp_t intro_exp(int k);
    if (k < 150) return mk($sformatf("walk%0d", k), (k / 6) % 4, 100 + 2 * k, 500, 1, 0, 1, 0);
    if (k < 210) return mk($sformatf("sniff%0d", k), 4, 400, 500, 1, 0, 1, 0);
    if (k < 240) return mk($sformatf("jup%0d", k), (k == 210 + 30) ? 6 : 5, 400, 500 - 4 * (k - 210), 1, 0, 1, 0);
    if (k < 285) return mk($sformatf("jdn%0d", k), 6, 400, 380 + 4 * (k - 240), 1, 0, 1, 0);
    return idle_exp("intro_done", 1);
  endfunction

  // Expected outputs after pop-up tick k for catch (laugh=0) or laugh scenes.
  function automatic exp_t pop_exp(int k, bit laugh, int cx);
    int y;
    if (k >= 190) return idle_exp(laugh ? "laugh_done" : "catch_done", 1);
    if (k <= 50)       y = 560 - 2 * k;
    else if (k <= 140) y = 460;
    else               y = 460 + 2 * (k - 140);
    return mk($sformatf("%s%0d", laugh ? "laugh" : "catch", k),
              laugh ? (((k / 6) % 2 == 1) ? 8 : 7) : 0,
              laugh ? 480 : cx, y, laugh, !laugh, 1, 0);
  endfunction

  task automatic cmp_vec(input exp_t e);
    n_checks++;
    if (int'(dog_select) !== e.sel || int'(dog_xpos) !== e.x || int'(dog_ypos) !== e.y ||
        dog_visible !== e.vis || dog_bird_visible !== e.bird || busy !== e.bsy || done !== e.dn) begin
      n_err++;
      $display("FAIL %s: got sel=%0d x=%0d y=%0d vis=%0b bird=%0b busy=%0b done=%0b, want sel=%0d x=%0d y=%0d vis=%0b bird=%0b busy=%0b done=%0b",
               e.nm, dog_select, dog_xpos, dog_ypos, dog_visible, dog_bird_visible, busy, done,
               e.sel, e.x, e.y, e.vis, e.bird, e.bsy, e.dn);
    end
  endtask

  task automatic cmp_int(input string nm, input int act, input int want);
    n_checks++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, act, want);
    end
  endtask

  // Monitor: compare after every tick edge and every marked strobe cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (!rst && (frame_tick || mon_strobe)) begin
        @(negedge clk);
        if (sb_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL sb_underflow: got output with no expectation, want queued entry");
        end else begin
          e = sb_q.pop_front();
          cmp_vec(e);
        end
      end
    end
  end

  task automatic tick(input exp_t e);
    @(negedge clk);
    frame_tick = 1'b1;
    sb_q.push_back(e);
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic strobe(input bit si, input bit sc, input bit sl, input int cx, input exp_t e);
    @(negedge clk);
    start_intro = si; start_catch = sc; start_laugh = sl;
    catch_x     = 11'(cx);
    mon_strobe  = 1'b1;
    sb_q.push_back(e);
    @(negedge clk);
    start_intro = 1'b0; start_catch = 1'b0; start_laugh = 1'b0;
    mon_strobe  = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion, want finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    repeat (3) @(negedge clk);
    cmp_vec(idle_exp("reset_state", 0));
    rst = 1'b0;
    repeat (2) @(negedge clk);
    cmp_vec(idle_exp("idle_after_reset", 0));

    // Reset mid-walk at x=200.
    base = done_total;
    strobe(1, 0, 0, 0, intro_exp(0));
    for (int k = 1; k <= 50; k++) tick(intro_exp(k));
    @(negedge clk);
    #1 rst = 1'b1;
    #1 cmp_vec(idle_exp("reset_mid_walk", 0));
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    cmp_int("reset_no_done", done_total - base, 0);

    // Intro with simultaneous catch request; laugh pulsed while busy.
    base = done_total;
    strobe(1, 1, 0, 300, intro_exp(0));
    for (int k = 1; k <= 285; k++) begin
      tick(intro_exp(k));
      if (k == 20) begin
        @(negedge clk) start_laugh = 1'b1;
        @(negedge clk) start_laugh = 1'b0;
      end
    end
    for (int k = 0; k < 3; k++) tick(idle_exp("intro_idle_after", 0));
    cmp_int("intro_done_count", done_total - base, 1);

    // Catch scene with a long frame_tick stall mid-HOLD.
    base = done_total;
    strobe(0, 1, 0, 250, pop_exp(0, 0, 250));
    for (int k = 1; k <= 80; k++) tick(pop_exp(k, 0, 250));
    repeat (500) @(negedge clk);
    strobe(0, 0, 0, 0, pop_exp(80, 0, 250));
    repeat (500) @(negedge clk);
    strobe(0, 0, 0, 0, pop_exp(80, 0, 250));
    for (int k = 81; k <= 190; k++) tick(pop_exp(k, 0, 250));
    tick(idle_exp("catch_idle_after", 0));
    cmp_int("catch_done_count", done_total - base, 1);

    // Laugh scene.
    base = done_total;
    strobe(0, 0, 1, 0, pop_exp(0, 1, 0));
    for (int k = 1; k <= 190; k++) tick(pop_exp(k, 1, 0));
    tick(idle_exp("laugh_idle_after", 0));
    cmp_int("laugh_done_count", done_total - base, 1);

    repeat (4) @(negedge clk);
    cmp_int("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
